// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the fetch sequencer and the decoder: opcode constants,
// fetch FSM encoding and the J-type immediate extractor.
package fetch_ctrl_pkg;

    localparam logic [6:0] OP_JAL = 7'b1101111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_t;

    // Sign-extended J-type immediate; bit 0 is always zero.
    function automatic logic [31:0] jal_imm(input logic [31:0] inst);
        return {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    endfunction

endpackage

// File: rtl/jal_predecode.sv
// Static next-PC predictor: JAL targets are taken, everything else falls through.
// Purely combinational so the decoder can share it.
module jal_predecode
    import fetch_ctrl_pkg::*;
#(
    parameter bit PREDECODE_JAL = 1'b1
) (
    input  logic [31:0] pc,
    input  logic [31:0] inst,
    output logic [31:0] next_pc
);

    logic is_jal;

    assign is_jal  = PREDECODE_JAL && (inst[6:0] == OP_JAL);
    // Both sums wrap modulo 2^32; misaligned targets are left to the back end.
    assign next_pc = is_jal ? (pc + jal_imm(inst)) : (pc + 32'd4);

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: one outstanding icache read, pushes returned words with their
// PC into the instruction queue, and restarts cleanly on back-end redirects.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC      = 32'h0000_0000,
    parameter bit          PREDECODE_JAL = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        q_full,
    output logic        ic_req,
    output logic [31:0] ic_addr,
    input  logic        ic_resp,
    input  logic [31:0] ic_inst,
    output logic        inst_rdy,
    output logic [31:0] inst,
    output logic [31:0] pc_out
);

    fetch_state_t state_reg, state_next;
    logic [31:0]  pc_reg, pc_next;
    logic         ic_req_reg, ic_req_next;
    logic [31:0]  ic_addr_reg, ic_addr_next;
    logic         inst_rdy_reg, inst_rdy_next;
    logic [31:0]  inst_reg, inst_next;
    logic [31:0]  pc_out_reg, pc_out_next;
    logic [31:0]  predicted_pc;

    jal_predecode #(
        .PREDECODE_JAL (PREDECODE_JAL)
    ) u_predecode (
        .pc      (pc_reg),
        .inst    (ic_inst),
        .next_pc (predicted_pc)
    );

    always_comb begin
        state_next    = state_reg;
        pc_next       = pc_reg;
        ic_req_next   = 1'b0;
        ic_addr_next  = ic_addr_reg;
        inst_rdy_next = 1'b0;
        inst_next     = inst_reg;
        pc_out_next   = pc_out_reg;

        case (state_reg)
            ST_IDLE: begin
                if (redirect) begin
                    pc_next = redirect_pc;
                end else if (!q_full) begin
                    ic_req_next  = 1'b1;
                    ic_addr_next = pc_reg;
                    state_next   = ST_WAIT;
                end
            end

            ST_WAIT: begin
                // A redirect kills the fetch even if its word is arriving right now.
                if (redirect) begin
                    pc_next    = redirect_pc;
                    state_next = ic_resp ? ST_IDLE : ST_DRAIN;
                end else if (ic_resp) begin
                    inst_rdy_next = 1'b1;
                    inst_next     = ic_inst;
                    pc_out_next   = pc_reg;
                    pc_next       = predicted_pc;
                    state_next    = ST_IDLE;
                end
            end

            ST_DRAIN: begin
                // Stale word is swallowed here; the latest redirect target is kept.
                if (redirect) begin
                    pc_next = redirect_pc;
                end
                if (ic_resp) begin
                    state_next = ST_IDLE;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            pc_reg       <= RESET_PC;
            ic_req_reg   <= 1'b0;
            ic_addr_reg  <= 32'd0;
            inst_rdy_reg <= 1'b0;
            inst_reg     <= 32'd0;
            pc_out_reg   <= 32'd0;
        end else if (rdy) begin
            state_reg    <= state_next;
            pc_reg       <= pc_next;
            ic_req_reg   <= ic_req_next;
            ic_addr_reg  <= ic_addr_next;
            inst_rdy_reg <= inst_rdy_next;
            inst_reg     <= inst_next;
            pc_out_reg   <= pc_out_next;
        end
    end

    // Pulses are masked while frozen; the held register re-emits them once rdy returns.
    assign ic_req   = ic_req_reg & rdy;
    assign inst_rdy = inst_rdy_reg & rdy;
    assign ic_addr  = ic_addr_reg;
    assign inst     = inst_reg;
    assign pc_out   = pc_out_reg;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: expected icache addresses and queue pushes are
// queued as stimulus is applied and popped as the DUT produces them.
module tb_fetch_ctrl;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } push_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        q_full;
    logic        ic_req;
    logic [31:0] ic_addr;
    logic        ic_resp = 1'b0;
    logic [31:0] ic_inst = 32'd0;
    logic        inst_rdy;
    logic [31:0] inst;
    logic [31:0] pc_out;

    logic [31:0] pd_pc, pd_inst, pd_next_on, pd_next_off;

    always #5 clk = ~clk;

    fetch_ctrl #(
        .RESET_PC      (32'h0000_0000),
        .PREDECODE_JAL (1'b1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rdy         (rdy),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .q_full      (q_full),
        .ic_req      (ic_req),
        .ic_addr     (ic_addr),
        .ic_resp     (ic_resp),
        .ic_inst     (ic_inst),
        .inst_rdy    (inst_rdy),
        .inst        (inst),
        .pc_out      (pc_out)
    );

    jal_predecode #(.PREDECODE_JAL(1'b1)) u_pd_on  (.pc(pd_pc), .inst(pd_inst), .next_pc(pd_next_on));
    jal_predecode #(.PREDECODE_JAL(1'b0)) u_pd_off (.pc(pd_pc), .inst(pd_inst), .next_pc(pd_next_off));

    logic [31:0] exp_addr_q[$];
    push_t       exp_push_q[$];
    logic [31:0] mem [logic [31:0]];
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          last_req_cyc = -1;
    bit          rate_chk = 1'b0;
    int          lat = 1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] fetch_word(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : NOP;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every request and every push must match the head of its queue.
    always @(negedge clk) begin
        if (ic_req) begin
            $display("[%0d] req  addr=%h", cyc, ic_addr);
            if (exp_addr_q.size() == 0) begin
                check_eq("spurious_req", 32'(ic_req), 32'd0);
            end else begin
                check_eq("ic_addr", ic_addr, exp_addr_q.pop_front());
                if (rate_chk && last_req_cyc >= 0)
                    check_eq("req_spacing", 32'(cyc - last_req_cyc), 32'd3);
            end
            last_req_cyc = cyc;
        end
        if (inst_rdy) begin
            $display("[%0d] push pc=%h inst=%h", cyc, pc_out, inst);
            if (exp_push_q.size() == 0) begin
                check_eq("spurious_push", 32'(inst_rdy), 32'd0);
            end else begin
                push_t e;
                e = exp_push_q.pop_front();
                check_eq("pc_out", pc_out, e.pc);
                check_eq("inst", inst, e.word);
            end
        end
    end

    // Icache model with programmable latency; frozen like the rest of the core while rdy=0.
    bit          rdy_s = 1'b1;
    bit          req_s = 1'b0;
    logic [31:0] addr_s = 32'd0;
    bit          pend = 1'b0;
    int          cnt = 0;
    logic [31:0] pend_addr = 32'd0;

    always @(negedge clk) begin
        rdy_s  = rdy;
        req_s  = ic_req;
        addr_s = ic_addr;
    end

    always @(posedge clk) begin
        #1;
        if (rdy_s) begin
            ic_resp = 1'b0;
            if (req_s) begin
                pend      = 1'b1;
                cnt       = lat;
                pend_addr = addr_s;
            end
            if (pend) begin
                cnt--;
                if (cnt == 0) begin
                    ic_resp = 1'b1;
                    ic_inst = fetch_word(pend_addr);
                    pend    = 1'b0;
                end
            end
        end
    end

    task automatic step_neg();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_addr_empty(input string tag);
        int n = 0;
        while (exp_addr_q.size() != 0 && n < 60) begin
            step_neg();
            n++;
        end
        if (exp_addr_q.size() != 0) begin
            check_eq({tag, "_timeout"}, 32'(exp_addr_q.size()), 32'd0);
            exp_addr_q.delete();
        end
    endtask

    task automatic wait_push_empty(input string tag);
        int n = 0;
        while (exp_push_q.size() != 0 && n < 60) begin
            step_neg();
            n++;
        end
        if (exp_push_q.size() != 0) begin
            check_eq({tag, "_timeout"}, 32'(exp_push_q.size()), 32'd0);
            exp_push_q.delete();
        end
    endtask

    // From IDLE with q_full high: allow exactly one fetch of address a.
    task automatic fetch_one(input logic [31:0] a);
        exp_addr_q.push_back(a);
        exp_push_q.push_back(push_t'{pc: a, word: fetch_word(a)});
        q_full = 1'b0;
        wait_addr_empty("fetch_req");
        q_full = 1'b1;
        wait_push_empty("fetch_push");
    endtask

    // Start a fetch of a that will not be pushed; returns in the cycle the request is visible.
    task automatic launch_dropped(input logic [31:0] a, input string tag);
        exp_addr_q.push_back(a);
        q_full = 1'b0;
        wait_addr_empty(tag);
        q_full = 1'b1;
    endtask

    task automatic pd_case(input logic [31:0] pc, input logic [31:0] w,
                           input logic [31:0] exp_on, input logic [31:0] exp_off);
        pd_pc   = pc;
        pd_inst = w;
        #1;
        check_eq("pd_jal_on", pd_next_on, exp_on);
        check_eq("pd_jal_off", pd_next_off, exp_off);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; rdy = 1'b1; redirect = 1'b0; redirect_pc = 32'd0; q_full = 1'b0;
        pd_pc = 32'd0; pd_inst = 32'd0;
        mem[32'h100] = 32'h1000_006F;   // jal +0x100
        mem[32'h200] = 32'h0100_006F;   // jal +0x10

        // Predictor with and without JAL predecode, incl. backward jump and wraparound.
        pd_case(32'h0000_0100, 32'h1000_006F, 32'h0000_0200, 32'h0000_0104);
        pd_case(32'h0000_0200, 32'h0100_006F, 32'h0000_0210, 32'h0000_0204);
        pd_case(32'h0000_0000, 32'hFF9F_F06F, 32'hFFFF_FFF8, 32'h0000_0004);
        pd_case(32'hFFFF_FFFC, NOP,           32'h0000_0000, 32'h0000_0000);
        pd_case(32'h0000_0010, 32'h0000_0067, 32'h0000_0014, 32'h0000_0014);

        repeat (3) step_neg();
        check_eq("rst_ic_req", 32'(ic_req), 32'd0);
        check_eq("rst_ic_addr", ic_addr, 32'd0);
        check_eq("rst_inst_rdy", 32'(inst_rdy), 32'd0);
        check_eq("rst_inst", inst, 32'd0);
        check_eq("rst_pc_out", pc_out, 32'd0);

        // Free-running NOP stream from RESET_PC, one push per 3 cycles.
        for (int i = 0; i < 6; i++) begin
            exp_addr_q.push_back(32'(i * 4));
            exp_push_q.push_back(push_t'{pc: 32'(i * 4), word: NOP});
        end
        rate_chk = 1'b1;
        rst = 1'b0;
        wait_push_empty("t1");
        q_full = 1'b1;
        rate_chk = 1'b0;
        repeat (5) step_neg();

        // Redirect in IDLE to 0x100, then follow two predicted JALs.
        redirect = 1'b1; redirect_pc = 32'h100;
        step_neg();
        redirect = 1'b0;
        exp_addr_q.push_back(32'h100);
        exp_addr_q.push_back(32'h200);
        exp_addr_q.push_back(32'h210);
        exp_push_q.push_back(push_t'{pc: 32'h100, word: 32'h1000_006F});
        exp_push_q.push_back(push_t'{pc: 32'h200, word: 32'h0100_006F});
        exp_push_q.push_back(push_t'{pc: 32'h210, word: NOP});
        q_full = 1'b0;
        wait_push_empty("t2");
        q_full = 1'b1;

        // q_full raised while a word is in flight: it is still pushed, then no requests.
        exp_push_q.push_back(push_t'{pc: 32'h214, word: NOP});
        launch_dropped(32'h214, "t3_req");
        repeat (7) step_neg();
        check_eq("t3_inflight_pushed", 32'(exp_push_q.size()), 32'd0);
        fetch_one(32'h218);

        // Redirect in WAIT, word arrives two cycles later and is discarded.
        lat = 2;
        launch_dropped(32'h21C, "t4_req");
        redirect = 1'b1; redirect_pc = 32'h400;
        step_neg();
        redirect = 1'b0;
        repeat (6) step_neg();
        fetch_one(32'h400);

        // Redirect coincident with the response: word dropped.
        lat = 1;
        launch_dropped(32'h404, "t4b_req");
        step_neg();
        redirect = 1'b1; redirect_pc = 32'h480;
        step_neg();
        redirect = 1'b0;
        repeat (4) step_neg();
        fetch_one(32'h480);

        // Two redirects while draining: the later one wins.
        lat = 4;
        launch_dropped(32'h484, "t5_req");
        redirect = 1'b1; redirect_pc = 32'h500;
        step_neg();
        redirect_pc = 32'h600;
        step_neg();
        redirect = 1'b0;
        repeat (6) step_neg();
        fetch_one(32'h600);

        // Asynchronous reset mid-WAIT; the late response must be ignored.
        launch_dropped(32'h604, "t6_req");
        step_neg();
        #2;
        rst = 1'b1;
        #1;
        check_eq("async_ic_req", 32'(ic_req), 32'd0);
        check_eq("async_ic_addr", ic_addr, 32'd0);
        check_eq("async_inst_rdy", 32'(inst_rdy), 32'd0);
        check_eq("async_inst", inst, 32'd0);
        check_eq("async_pc_out", pc_out, 32'd0);
        step_neg();
        rst = 1'b0;
        repeat (8) step_neg();
        lat = 1;
        fetch_one(32'h0);

        // rdy low while the response is presented: one push after rdy returns.
        exp_push_q.push_back(push_t'{pc: 32'h4, word: NOP});
        launch_dropped(32'h4, "t6b_req");
        @(posedge clk); #2;
        rdy = 1'b0;
        repeat (3) begin
            step_neg();
            check_eq("frozen_inst_rdy", 32'(inst_rdy), 32'd0);
            check_eq("frozen_ic_req", 32'(ic_req), 32'd0);
        end
        @(posedge clk); #2;
        rdy = 1'b1;
        wait_push_empty("t6b_push");
        repeat (3) step_neg();

        // rdy low while the push pulse is pending: it must appear exactly once later.
        exp_push_q.push_back(push_t'{pc: 32'h8, word: NOP});
        launch_dropped(32'h8, "t6c_req");
        @(posedge clk);
        @(posedge clk); #2;
        rdy = 1'b0;
        repeat (3) begin
            step_neg();
            check_eq("held_inst_rdy", 32'(inst_rdy), 32'd0);
            check_eq("held_push_pending", 32'(exp_push_q.size()), 32'd1);
        end
        @(posedge clk); #2;
        rdy = 1'b1;
        wait_push_empty("t6c_push");
        repeat (4) step_neg();

        check_eq("addr_q_empty", 32'(exp_addr_q.size()), 32'd0);
        check_eq("push_q_empty", 32'(exp_push_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
